ex_stage_mul: RTL and testbench
===============================

Name: ex_stage_mul

Overview:
- Execute stage that consumes the ID/EX pipeline register outputs and produces the values captured by EX/MEM.
- Implements single-cycle ALU operations (add, sub, and, or, slt) and an iterative shift-add multiplier for R-type MUL.
- While a MUL is in progress it asserts stall_o, which freezes PC, IF/ID and ID/EX so its operands stay stable and injects a bubble into EX/MEM.

Parameters:
WIDTH, 32, datapath width; the multiply iteration count equals WIDTH.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
ALUSrc_i  input  1  1: operand B = SignExt_i, 0: operand B = RegData2_i
ALUOp_i  input  2  00 add, 01 sub, 10 decode funct, 11 reserved (treated as add)
RegDst_i  input  1  1: destination = RegAddrRd_i, 0: destination = RegAddrRt_i
RegData1_i  input  WIDTH  operand A
RegData2_i  input  WIDTH  register rt data (operand B source and store data)
SignExt_i  input  WIDTH  sign-extended immediate; bits [5:0] are funct
RegAddrRt_i  input  5  rt address
RegAddrRd_i  input  5  rd address
ALUResult_o  output  WIDTH  result to EX/MEM
WriteData_o  output  WIDTH  equals RegData2_i (store data)
RegAddrW_o  output  5  selected destination register
Zero_o  output  1  1 when ALUResult_o == 0
stall_o  output  1  pipeline hold request
mul_busy_o  output  1  FSM is in BUSY (debug/verification)

Behaviour:
- Funct decode (ALUOp=10): 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 0 or 1), 0x18 mul. Any other funct gives add.
- Arithmetic wraps modulo 2^WIDTH. MUL returns the low WIDTH bits of the product, identical for signed and unsigned operands.
- Non-MUL paths, RegAddrW_o, WriteData_o and Zero_o are combinational from the inputs (0 extra latency).
- is_mul = (ALUOp_i==10) && (SignExt_i[5:0]==0x18).
- FSM states:
  - IDLE: if is_mul, stall_o=1 combinationally. On the clock edge, latch mcand=RegData1_i, mplier=operand B, acc=0, cnt=0, go to BUSY. Otherwise stay in IDLE.
  - BUSY: stall_o=1. Each edge: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, cnt++. When cnt==WIDTH-1 at the edge, go to DONE. BUSY therefore lasts exactly WIDTH cycles.
  - DONE: stall_o=0, ALUResult_o=acc, Zero_o from acc. At the next edge (EX/MEM captures the product, the pipeline advances), go to IDLE unconditionally.
- Total stall for one MUL is WIDTH+1 cycles (IDLE detection cycle plus BUSY). The result is presented in the following cycle.
- Back-to-back MULs: the second MUL arrives in the cycle after DONE, when the FSM is in IDLE, and starts normally. DONE never restarts the same instruction.
- During BUSY, input changes are ignored for the product; only the latched operands are used.
- Operand B = 0 or operand A = 0: still takes the full WIDTH+1 stall cycles (no early exit); result 0, Zero_o=1 in DONE.
- Reset (rst_i=0, any time including mid-BUSY):
  - state=IDLE, acc=0, mcand=0, mplier=0, cnt=0, stall_o=0, mul_busy_o=0 immediately.
  - Combinational outputs follow their inputs.
  - A MUL that was in flight is abandoned.
- After reset release, a MUL still present on the inputs starts fresh from IDLE.

Test Plan:
- ALUOp=00, ALUSrc=1, RegData1=0x10, SignExt=0xFFFFFFFC, RegDst=0, Rt=5 -> ALUResult=0x0C, RegAddrW=5, stall_o=0, same cycle.
- ALUOp=01, RegData1=RegData2=0x1234, ALUSrc=0 -> ALUResult=0, Zero_o=1. Then funct 0x2A with A=0xFFFFFFFF, B=1 -> ALUResult=1.
- MUL A=7, B=6, Rd=9, RegDst=1 -> stall_o high for exactly 33 cycles, mul_busy_o high for 32, then one cycle with stall_o=0, ALUResult=42, RegAddrW=9, then IDLE.
- Back-to-back MUL 0xFFFFFFFF*0xFFFFFFFF followed by MUL 3*0x80000000 -> results 0x00000001 then 0x80000000, each with a 33-cycle stall, no lost or duplicated start.
- Assert rst_i low at BUSY cycle 10 of MUL 5*5 -> stall_o=0 and mul_busy_o=0 immediately. Release with MUL still on the inputs -> full 33-cycle stall, result 25.
- MUL with B=0 -> 33-cycle stall, ALUResult=0, Zero_o=1 in DONE.

Source files
------------

// File: rtl/ex_stage_mul.sv
// ex_stage_mul
// Execute stage: single-cycle ALU (add, sub, and, or, slt) plus an iterative
// shift-add multiplier for R-type MUL. While a multiply is running, stall_o
// holds PC, IF/ID and ID/EX so the operands stay put, and EX/MEM takes a bubble.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-low reset
//   ALUSrc_i     1: operand B = SignExt_i, 0: operand B = RegData2_i
//   ALUOp_i      00 add, 01 sub, 10 decode funct, 11 add
//   RegDst_i     1: destination = RegAddrRd_i, 0: destination = RegAddrRt_i
//   RegData1_i   operand A
//   RegData2_i   rt data (operand B source, store data)
//   SignExt_i    sign-extended immediate, [5:0] = funct
//   RegAddrRt_i  rt address
//   RegAddrRd_i  rd address
//   ALUResult_o  result to EX/MEM
//   WriteData_o  store data (RegData2_i)
//   RegAddrW_o   selected destination register
//   Zero_o       ALUResult_o == 0
//   stall_o      pipeline hold request
//   mul_busy_o   multiplier FSM is in BUSY
module ex_stage_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ALUSrc_i,
    input  logic [1:0]       ALUOp_i,
    input  logic             RegDst_i,
    input  logic [WIDTH-1:0] RegData1_i,
    input  logic [WIDTH-1:0] RegData2_i,
    input  logic [WIDTH-1:0] SignExt_i,
    input  logic [4:0]       RegAddrRt_i,
    input  logic [4:0]       RegAddrRd_i,
    output logic [WIDTH-1:0] ALUResult_o,
    output logic [WIDTH-1:0] WriteData_o,
    output logic [4:0]       RegAddrW_o,
    output logic             Zero_o,
    output logic             stall_o,
    output logic             mul_busy_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0] mplier_reg, mplier_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [WIDTH-1:0] operand_b;
    logic [5:0]       funct;
    logic             is_mul;
    logic [WIDTH-1:0] alu_result;

    assign operand_b   = ALUSrc_i ? SignExt_i : RegData2_i;
    assign funct       = SignExt_i[5:0];
    assign is_mul      = (ALUOp_i == 2'b10) && (funct == FUNCT_MUL);
    assign WriteData_o = RegData2_i;
    assign RegAddrW_o  = RegDst_i ? RegAddrRd_i : RegAddrRt_i;

    // Single-cycle ALU. In DONE the latched product replaces whatever the
    // ALU would compute, since the MUL instruction is still on the inputs.
    always_comb begin
        alu_result = RegData1_i + operand_b;
        case (ALUOp_i)
            2'b01: alu_result = RegData1_i - operand_b;
            2'b10: begin
                case (funct)
                    FUNCT_ADD: alu_result = RegData1_i + operand_b;
                    FUNCT_SUB: alu_result = RegData1_i - operand_b;
                    FUNCT_AND: alu_result = RegData1_i & operand_b;
                    FUNCT_OR:  alu_result = RegData1_i | operand_b;
                    FUNCT_SLT: alu_result = {{(WIDTH-1){1'b0}},
                                             ($signed(RegData1_i) < $signed(operand_b))};
                    FUNCT_MUL: alu_result = '0;
                    default:   alu_result = RegData1_i + operand_b;
                endcase
            end
            default: alu_result = RegData1_i + operand_b;
        endcase
        if (state_reg == ST_DONE) begin
            alu_result = acc_reg;
        end
    end

    assign ALUResult_o = alu_result;
    assign Zero_o      = (alu_result == '0);

    // Stall is gated by reset so it drops the instant reset is asserted, even
    // though a MUL may still be sitting on the inputs.
    assign stall_o    = rst_i && (((state_reg == ST_IDLE) && is_mul) || (state_reg == ST_BUSY));
    assign mul_busy_o = (state_reg == ST_BUSY);

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (is_mul) begin
                    mcand_next  = RegData1_i;
                    mplier_next = operand_b;
                    acc_next    = '0;
                    cnt_next    = '0;
                    state_next  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // No early exit on zero operands: fixed latency keeps the
                // hazard unit's view of the stall simple.
                if (mplier_reg[0]) begin
                    acc_next = acc_reg + mcand_reg;
                end
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg  <= ST_IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
        end
    end

endmodule

// File: tb/tb_ex_stage_mul.sv
// Testbench for ex_stage_mul: directed vectors; expected responses are queued
// at issue time and a negedge monitor pops one whenever stall_o is low.
module tb_ex_stage_mul;

    localparam int W = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          ALUSrc_i;
    logic [1:0]    ALUOp_i;
    logic          RegDst_i;
    logic [W-1:0]  RegData1_i;
    logic [W-1:0]  RegData2_i;
    logic [W-1:0]  SignExt_i;
    logic [4:0]    RegAddrRt_i;
    logic [4:0]    RegAddrRd_i;
    logic [W-1:0]  ALUResult_o;
    logic [W-1:0]  WriteData_o;
    logic [4:0]    RegAddrW_o;
    logic          Zero_o;
    logic          stall_o;
    logic          mul_busy_o;

    ex_stage_mul #(.WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ALUSrc_i    (ALUSrc_i),
        .ALUOp_i     (ALUOp_i),
        .RegDst_i    (RegDst_i),
        .RegData1_i  (RegData1_i),
        .RegData2_i  (RegData2_i),
        .SignExt_i   (SignExt_i),
        .RegAddrRt_i (RegAddrRt_i),
        .RegAddrRd_i (RegAddrRd_i),
        .ALUResult_o (ALUResult_o),
        .WriteData_o (WriteData_o),
        .RegAddrW_o  (RegAddrW_o),
        .Zero_o      (Zero_o),
        .stall_o     (stall_o),
        .mul_busy_o  (mul_busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string        name;
        logic [W-1:0] result;
        logic         zero;
        logic [4:0]   addr;
        logic [W-1:0] wdata;
        int           stalls;
        int           busys;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;
    int   stall_cnt = 0;
    int   busy_cnt = 0;
    bit   done = 1'b0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    // Drive one instruction and queue its expected response.
    task automatic drive(input logic [1:0] op, input logic src, input logic dst,
                         input logic [W-1:0] a, input logic [W-1:0] b2,
                         input logic [W-1:0] sx, input logic [4:0] rt, input logic [4:0] rd);
        ALUOp_i = op; ALUSrc_i = src; RegDst_i = dst;
        RegData1_i = a; RegData2_i = b2; SignExt_i = sx;
        RegAddrRt_i = rt; RegAddrRd_i = rd;
    endtask

    task automatic expect_out(input string nm, input logic [W-1:0] res, input logic [4:0] addr,
                              input int stalls);
        exp_t e;
        e.name = nm; e.result = res; e.zero = (res == '0); e.addr = addr;
        e.wdata = RegData2_i; e.stalls = stalls; e.busys = (stalls > 0) ? stalls - 1 : 0;
        exp_q.push_back(e);
    endtask

    // Wait for the cycle in which the current instruction leaves EX, then step
    // to just after the next rising edge.
    task automatic wait_done(input string nm);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (stall_o && n < 100);
        if (stall_o) begin
            checks++; errors++;
            $display("FAIL %s timeout: stall_o still 1 after %0d cycles, expected release", nm, n);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input string nm, input logic [1:0] op, input logic src, input logic dst,
                         input logic [W-1:0] a, input logic [W-1:0] b2, input logic [W-1:0] sx,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [W-1:0] res, input logic [4:0] addr, input int stalls);
        drive(op, src, dst, a, b2, sx, rt, rd);
        expect_out(nm, res, addr, stalls);
        wait_done(nm);
    endtask

    // Monitor / scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            stall_cnt = 0;
            busy_cnt  = 0;
        end else if (!done) begin
            if (stall_o) begin
                stall_cnt++;
                if (mul_busy_o) busy_cnt++;
            end else if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: result 0x%08h with empty queue, expected none", ALUResult_o);
            end else begin
                cur = exp_q.pop_front();
                chk({cur.name, ".result"}, ALUResult_o, cur.result);
                chk({cur.name, ".zero"}, W'(Zero_o), W'(cur.zero));
                chk({cur.name, ".addr"}, W'(RegAddrW_o), W'(cur.addr));
                chk({cur.name, ".wdata"}, WriteData_o, cur.wdata);
                chk({cur.name, ".stall_cycles"}, W'(stall_cnt), W'(cur.stalls));
                chk({cur.name, ".busy_cycles"}, W'(busy_cnt), W'(cur.busys));
                chk({cur.name, ".busy_at_out"}, W'(mul_busy_o), '0);
                $display("txn %-10s result=0x%08h zero=%0d addr=%0d stalls=%0d busy=%0d",
                         cur.name, ALUResult_o, Zero_o, RegAddrW_o, stall_cnt, busy_cnt);
                stall_cnt = 0;
                busy_cnt  = 0;
            end
        end
    end

    localparam logic [W-1:0] F_MUL = 32'h0000_0018;

    initial begin
        int n;
        rst_i = 1'b0;
        // A MUL on the inputs during reset must not request a stall.
        drive(2'b10, 1'b0, 1'b1, 32'd7, 32'd6, F_MUL, 5'd1, 5'd9);
        #3;
        chk("reset.stall", W'(stall_o), '0);
        chk("reset.busy", W'(mul_busy_o), '0);
        chk("reset.mul_result", ALUResult_o, '0);
        drive(2'b00, 1'b1, 1'b0, 32'h10, 32'h55, 32'hFFFF_FFFC, 5'd5, 5'd7);
        #1;
        chk("reset.comb_add", ALUResult_o, 32'h0C);
        chk("reset.comb_addr", W'(RegAddrW_o), 32'd5);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        issue("add_imm", 2'b00, 1'b1, 1'b0, 32'h10, 32'hAAAA_5555, 32'hFFFF_FFFC, 5'd5, 5'd7,
              32'h0000_000C, 5'd5, 0);
        issue("sub_zero", 2'b01, 1'b0, 1'b1, 32'h1234, 32'h1234, 32'h0, 5'd2, 5'd3,
              32'h0, 5'd3, 0);
        issue("slt_true", 2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd2, 5'd4,
              32'd1, 5'd4, 0);
        issue("slt_false", 2'b10, 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'h2A, 5'd2, 5'd4,
              32'd0, 5'd4, 0);
        issue("and", 2'b10, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h24, 5'd2, 5'd6,
              32'hF000_F000, 5'd6, 0);
        issue("or", 2'b10, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h25, 5'd2, 5'd6,
              32'hFFF0_FFF0, 5'd6, 0);
        issue("sub_funct", 2'b10, 1'b0, 1'b1, 32'd5, 32'd7, 32'h22, 5'd2, 5'd8,
              32'hFFFF_FFFE, 5'd8, 0);
        issue("op11_add", 2'b11, 1'b0, 1'b0, 32'd3, 32'd4, 32'h18, 5'd11, 5'd8,
              32'd7, 5'd11, 0);
        issue("bad_funct", 2'b10, 1'b0, 1'b1, 32'd3, 32'd4, 32'h00, 5'd2, 5'd8,
              32'd7, 5'd8, 0);

        issue("mul_7x6", 2'b10, 1'b0, 1'b1, 32'd7, 32'd6, F_MUL, 5'd1, 5'd9,
              32'd42, 5'd9, 33);
        issue("add_after", 2'b00, 1'b0, 1'b0, 32'd1, 32'd2, 32'h0, 5'd10, 5'd9,
              32'd3, 5'd10, 0);
        issue("mul_m1sq", 2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, F_MUL, 5'd1, 5'd12,
              32'h0000_0001, 5'd12, 33);
        issue("mul_3xmsb", 2'b10, 1'b0, 1'b1, 32'd3, 32'h8000_0000, F_MUL, 5'd1, 5'd13,
              32'h8000_0000, 5'd13, 33);
        issue("mul_bzero", 2'b10, 1'b0, 1'b1, 32'h1234_5678, 32'h0, F_MUL, 5'd1, 5'd14,
              32'h0, 5'd14, 33);

        // MUL 5*5 interrupted by reset at BUSY cycle 10, then restarted.
        drive(2'b10, 1'b0, 1'b1, 32'd5, 32'd5, F_MUL, 5'd1, 5'd15);
        n = 0;
        for (int i = 0; i < 20 && n < 10; i++) begin
            @(negedge clk_i);
            if (mul_busy_o) n++;
        end
        chk("midreset.busy_seen", W'(n), 32'd10);
        #2;
        rst_i = 1'b0;
        #1;
        chk("midreset.stall", W'(stall_o), '0);
        chk("midreset.busy", W'(mul_busy_o), '0);
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        expect_out("mul_5x5", 32'd25, 5'd15, 33);
        rst_i = 1'b1;
        wait_done("mul_5x5");

        issue("add_final", 2'b00, 1'b1, 1'b0, 32'd100, 32'd0, 32'hFFFF_FF9C, 5'd16, 5'd0,
              32'd0, 5'd16, 0);

        done = 1'b1;
        chk("queue_drained", W'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
